ysyx_25030093_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_25030093_mem_arbiter
// PURPOSE
//  Shares the single instruction/data SRAM port between the IFU (master 0, read-only)
//  and the LSU (master 1, read/write). Round-robin arbitration; one transaction in
//  flight at a time. Owner is held from request handshake through response handshake.
//  Sits between IFU/LSU and the SRAM model; every interface uses a valid/ready pair.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width
//  TIMEOUT  255  response-wait cycle limit before err asserts (8-bit counter)
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous reset, active-low
//  m0_req_valid in  1     IFU fetch request
//  m0_req_ready out 1     IFU request accepted
//  m0_addr     in   AW    IFU fetch address (pc)
//  m0_rsp_valid out 1     IFU response valid
//  m0_rsp_ready in  1     IFU can take response
//  m0_rdata    out  DW    instruction word
//  m1_req_valid in  1     LSU request
//  m1_req_ready out 1     LSU request accepted
//  m1_addr     in   AW    LSU address
//  m1_wen      in   1     1 = write, 0 = read
//  m1_wdata    in   DW    write data
//  m1_wmask    in   DW/8  byte strobes
//  m1_rsp_valid out 1     LSU response valid (read data or write ack)
//  m1_rsp_ready in  1     LSU can take response
//  m1_rdata    out  DW    load data
//  s_req_valid out  1     SRAM request
//  s_req_ready in   1     SRAM accepted request
//  s_addr/s_wen/s_wdata/s_wmask out AW/1/DW/DW/8  muxed from owner; m0 drives wen=0, wmask=0
//  s_rsp_valid in   1     SRAM response
//  s_rsp_ready out  1     forwarded from owner's rsp_ready
//  s_rdata     in   DW    SRAM read data
//  busy        out  1     state != IDLE
//  err         out  1     sticky: a response wait reached TIMEOUT
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, last=1 (LSU), wait_cnt=0, err=0; all valid/ready
//    outputs 0, busy=0. Reset mid-transaction abandons it; no response delivered after.
//  - States: IDLE, REQ0, REQ1, RSP0, RSP1.
//  - IDLE: only m0 valid -> REQ0; only m1 -> REQ1; both -> the one != last.
//    On entering REQx, last<=x. Arbitration costs 1 cycle: no request passes in IDLE.
//  - REQx: s_req_valid=1, s_* muxed from master x, mx_req_ready=s_req_ready; other
//    master's req_ready=0. On s_req_valid&&s_req_ready -> RSPx. Masters must hold
//    request fields stable until handshake.
//  - RSPx: mx_rsp_valid=s_rsp_valid, mx_rdata=s_rdata, s_rsp_ready=mx_rsp_ready; other
//    rsp_valid=0. On s_rsp_valid&&s_rsp_ready -> IDLE. Back-to-back transactions therefore
//    need >= 3 cycles each (IDLE, REQ, RSP).
//  - wait_cnt: cleared entering RSPx, +1 each RSP cycle with no response handshake,
//    saturates at TIMEOUT; reaching TIMEOUT sets err (sticky until reset). State unchanged.
//  - Ungranted master: req_ready=0, rsp_valid=0, its rdata=0.
//  - Requests arriving during REQ/RSP wait; a valid dropped before grant is ignored.
//  - Write ack: m1_rsp_valid on s_rsp_valid, m1_rdata = s_rdata (don't-care to LSU).
// TESTING
//  1 Reset: rst=0 with m0/m1 valid -> all ready/valid outs 0, busy=0, err=0; release ->
//    IFU granted first (last=1).
//  2 IFU alone: m0_addr=0x8000_0000, SRAM ready immediately, rdata=0x0000_0413 1 cycle
//    later -> m0_rsp_valid with 0x0000_0413, m1 outputs idle, 3 cycles total.
//  3 Contention: m0 and m1 valid continuously -> grants alternate 0,1,0,1; LSU write
//    addr=0x8000_0100 wdata=0xDEAD_BEEF wmask=4'hF appears on s_* only in REQ1.
//  4 Response back-pressure: m1_rsp_ready=0 for 5 cycles with s_rsp_valid=1 ->
//    s_rsp_ready=0, state held RSP1, completes on cycle ready rises.
//  5 Timeout: TIMEOUT=4, SRAM never responds -> err=1 after 4 RSP cycles, stays 1;
//    cleared only by rst=0.
//  6 Reset mid-RSP0: rst=0 during RSP0 -> IDLE immediately, late s_rsp_valid not forwarded.

Source files
------------

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Round-robin arbiter sharing one SRAM valid/ready port between the IFU (m0, read-only)
// and the LSU (m1, read/write). One transaction in flight; owner held until response handshake.
module ysyx_25030093_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            m0_req_valid_i,
    output logic            m0_req_ready_o,
    input  logic [AW-1:0]   m0_addr_i,
    output logic            m0_rsp_valid_o,
    input  logic            m0_rsp_ready_i,
    output logic [DW-1:0]   m0_rdata_o,
    input  logic            m1_req_valid_i,
    output logic            m1_req_ready_o,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic            m1_wen_i,
    input  logic [DW-1:0]   m1_wdata_i,
    input  logic [DW/8-1:0] m1_wmask_i,
    output logic            m1_rsp_valid_o,
    input  logic            m1_rsp_ready_i,
    output logic [DW-1:0]   m1_rdata_o,
    output logic            s_req_valid_o,
    input  logic            s_req_ready_i,
    output logic [AW-1:0]   s_addr_o,
    output logic            s_wen_o,
    output logic [DW-1:0]   s_wdata_o,
    output logic [DW/8-1:0] s_wmask_o,
    input  logic            s_rsp_valid_i,
    output logic            s_rsp_ready_o,
    input  logic [DW-1:0]   s_rdata_i,
    output logic            busy_o,
    output logic            err_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        REQ1 = 3'd2,
        RSP0 = 3'd3,
        RSP1 = 3'd4
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
    logic       owner_rsp_ready_s;
    logic       rsp_hs_s;

    // Only meaningful in RSP states; selects the owner's response-ready
    assign owner_rsp_ready_s = (state_q == RSP1) ? m1_rsp_ready_i : m0_rsp_ready_i;
    assign rsp_hs_s          = s_rsp_valid_i && owner_rsp_ready_s;

    // State, round-robin pointer, response-wait counter and sticky error registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state: arbitrate in IDLE, advance on request/response handshakes
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (m0_req_valid_i && m1_req_valid_i) begin
                    if (last_q) begin
                        state_d = REQ0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = REQ1;
                        last_d  = 1'b1;
                    end
                end else if (m0_req_valid_i) begin
                    state_d = REQ0;
                    last_d  = 1'b0;
                end else if (m1_req_valid_i) begin
                    state_d = REQ1;
                    last_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ0, REQ1: begin
                if (s_req_ready_i) begin
                    state_d    = (state_q == REQ1) ? RSP1 : RSP0;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            RSP0, RSP1: begin
                if (rsp_hs_s) begin
                    state_d = IDLE;
                end else begin
                    if (wait_cnt_q != TIMEOUT_C) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                    // err latches on the cycle the counter lands on the limit
                    if (wait_cnt_d == TIMEOUT_C) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: steer SRAM and master handshakes from the current owner only
    always_comb begin
        m0_req_ready_o = 1'b0;
        m0_rsp_valid_o = 1'b0;
        m0_rdata_o     = '0;
        m1_req_ready_o = 1'b0;
        m1_rsp_valid_o = 1'b0;
        m1_rdata_o     = '0;
        s_req_valid_o  = 1'b0;
        s_addr_o       = '0;
        s_wen_o        = 1'b0;
        s_wdata_o      = '0;
        s_wmask_o      = '0;
        s_rsp_ready_o  = 1'b0;
        case (state_q)
            IDLE: begin
                s_req_valid_o = 1'b0;
            end
            REQ0: begin
                s_req_valid_o  = 1'b1;
                s_addr_o       = m0_addr_i;
                m0_req_ready_o = s_req_ready_i;
            end
            REQ1: begin
                s_req_valid_o  = 1'b1;
                s_addr_o       = m1_addr_i;
                s_wen_o        = m1_wen_i;
                s_wdata_o      = m1_wdata_i;
                s_wmask_o      = m1_wmask_i;
                m1_req_ready_o = s_req_ready_i;
            end
            RSP0: begin
                m0_rsp_valid_o = s_rsp_valid_i;
                m0_rdata_o     = s_rdata_i;
                s_rsp_ready_o  = m0_rsp_ready_i;
            end
            RSP1: begin
                m1_rsp_valid_o = s_rsp_valid_i;
                m1_rdata_o     = s_rdata_i;
                s_rsp_ready_o  = m1_rsp_ready_i;
            end
            default: s_req_valid_o = 1'b0;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign err_o  = err_q;

endmodule

// File: tb/tb_ysyx_25030093_mem_arbiter.sv
// Randomized and directed bench for the IFU/LSU SRAM arbiter, checked every cycle against
// a transaction-level model of the arbitration rules.
module tb_ysyx_25030093_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_ni = 1'b0;
    logic            m0_req_valid = 1'b0, m0_req_ready, m0_rsp_valid, m0_rsp_ready = 1'b0;
    logic [AW-1:0]   m0_addr = '0;
    logic [DW-1:0]   m0_rdata;
    logic            m1_req_valid = 1'b0, m1_req_ready, m1_wen = 1'b0, m1_rsp_valid, m1_rsp_ready = 1'b0;
    logic [AW-1:0]   m1_addr = '0;
    logic [DW-1:0]   m1_wdata = '0, m1_rdata;
    logic [DW/8-1:0] m1_wmask = '0;
    logic            s_req_valid, s_req_ready = 1'b0, s_wen, s_rsp_valid = 1'b0, s_rsp_ready;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata, s_rdata = '0;
    logic [DW/8-1:0] s_wmask;
    logic            busy, err;

    ysyx_25030093_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready), .m0_addr_i(m0_addr),
        .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_ready_i(m0_rsp_ready), .m0_rdata_o(m0_rdata),
        .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready), .m1_addr_i(m1_addr),
        .m1_wen_i(m1_wen), .m1_wdata_i(m1_wdata), .m1_wmask_i(m1_wmask),
        .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_ready_i(m1_rsp_ready), .m1_rdata_o(m1_rdata),
        .s_req_valid_o(s_req_valid), .s_req_ready_i(s_req_ready), .s_addr_o(s_addr),
        .s_wen_o(s_wen), .s_wdata_o(s_wdata), .s_wmask_o(s_wmask),
        .s_rsp_valid_i(s_rsp_valid), .s_rsp_ready_o(s_rsp_ready), .s_rdata_i(s_rdata),
        .busy_o(busy), .err_o(err)
    );

    wire [7:0] flags = {m0_req_ready, m0_rsp_valid, m1_req_ready, m1_rsp_valid,
                        s_req_valid, s_rsp_ready, busy, err};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = arbitrating/free, 1 = request offered, 2 = awaiting response
    int   md_phase = 0, md_owner = 0, md_last = 1, md_wait = 0;
    bit   md_err = 1'b0;
    logic [7:0]    e_flags;
    logic [DW-1:0] e_rd0, e_rd1;
    logic          own_rsp_ready;

    always @(negedge clk) begin : compare
        if (!rst_ni) begin
            md_phase = 0; md_owner = 0; md_last = 1; md_wait = 0; md_err = 1'b0;
            check("reset_flags", flags, 8'h00);
        end else begin
            own_rsp_ready = (md_owner == 1) ? m1_rsp_ready : m0_rsp_ready;
            e_flags = 8'h00;
            e_rd0 = '0;
            e_rd1 = '0;
            if (md_phase == 1) begin
                e_flags[3] = 1'b1;
                if (md_owner == 0) e_flags[7] = s_req_ready;
                else               e_flags[5] = s_req_ready;
            end else if (md_phase == 2) begin
                e_flags[2] = own_rsp_ready;
                if (md_owner == 0) begin e_flags[6] = s_rsp_valid; e_rd0 = s_rdata; end
                else               begin e_flags[4] = s_rsp_valid; e_rd1 = s_rdata; end
            end
            e_flags[1] = (md_phase != 0);
            e_flags[0] = md_err;
            check("flags", flags, e_flags);
            check("m0_rdata", m0_rdata, e_rd0);
            check("m1_rdata", m1_rdata, e_rd1);
            if (md_phase == 1) begin
                check("s_addr", s_addr, (md_owner == 1) ? m1_addr : m0_addr);
                check("s_wdata", s_wdata, (md_owner == 1) ? m1_wdata : 32'd0);
                check("s_ctl", {s_wen, s_wmask}, (md_owner == 1) ? {m1_wen, m1_wmask} : 5'd0);
            end
            // advance the model one clock
            if (md_phase == 0) begin
                if (m0_req_valid || m1_req_valid) begin
                    if (m0_req_valid && m1_req_valid) md_owner = 1 - md_last;
                    else                              md_owner = m0_req_valid ? 0 : 1;
                    md_last  = md_owner;
                    md_phase = 1;
                end
            end else if (md_phase == 1) begin
                if (s_req_ready) begin md_phase = 2; md_wait = 0; end
            end else begin
                if (s_rsp_valid && own_rsp_ready) md_phase = 0;
                else if (md_wait < TMO) begin
                    md_wait++;
                    if (md_wait == TMO) md_err = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic quiet();
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; m1_wen = 1'b0;
        m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
        s_req_ready = 1'b0; s_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst_ni = 1'b0;
        quiet();
        sample();
    endtask

    int grants[8];
    int ng;

    initial begin
        // reset with both masters asking; IFU must win first
        tick();
        rst_ni = 1'b0; m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
        sample();
        check("t1_rst_flags", flags, 8'h00);
        tick(); rst_ni = 1'b1;
        sample();
        check("t1_arb_cycle", s_req_valid, 1'b0);
        tick();
        sample();
        check("t1_first_grant", {s_req_valid, s_addr}, {1'b1, 32'h0000_1000});

        // IFU alone: fetch in three cycles
        do_reset();
        tick(); rst_ni = 1'b1; m0_req_valid = 1'b1; m0_addr = 32'h8000_0000;
        s_req_ready = 1'b1; m0_rsp_ready = 1'b1;
        sample();
        tick();
        sample();
        check("t2_req", {m0_req_ready, s_addr}, {1'b1, 32'h8000_0000});
        tick(); m0_req_valid = 1'b0; s_rsp_valid = 1'b1; s_rdata = 32'h0000_0413;
        sample();
        check("t2_rsp", {m0_rsp_valid, m0_rdata, m1_rsp_valid}, {1'b1, 32'h0000_0413, 1'b0});
        tick(); s_rsp_valid = 1'b0;
        sample();
        check("t2_done", busy, 1'b0);

        // contention: grants alternate, LSU write fields only while LSU is offered
        do_reset();
        tick(); rst_ni = 1'b1;
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0040;
        m1_req_valid = 1'b1; m1_addr = 32'h8000_0100; m1_wen = 1'b1;
        m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF;
        s_req_ready = 1'b1; s_rsp_valid = 1'b1; m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) tick();
            sample();
            if (s_req_valid && s_req_ready && ng < 8) begin
                grants[ng] = m1_req_ready ? 1 : 0;
                ng++;
                if (m1_req_ready) check("t3_wr_fields", {s_wen, s_wmask, s_addr, s_wdata},
                                        {1'b1, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF});
                else              check("t3_m0_ctl", {s_wen, s_wmask}, 5'd0);
            end else begin
                check("t3_no_wdata", s_wdata == 32'hDEAD_BEEF, 1'b0);
            end
        end
        check("t3_ngrants", ng, 4);
        for (int i = 0; i < 4; i++) check("t3_grant_order", grants[i], i % 2);

        // LSU response back-pressure
        do_reset();
        tick(); rst_ni = 1'b1; m1_req_valid = 1'b1; m1_wen = 1'b0; m1_addr = 32'h8000_0200;
        s_req_ready = 1'b1;
        sample();
        tick();
        sample();
        check("t4_req", m1_req_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(); m1_req_valid = 1'b0; s_rsp_valid = 1'b1; m1_rsp_ready = 1'b0;
            sample();
            check("t4_hold", {s_rsp_ready, busy, m1_rsp_valid}, 3'b011);
        end
        tick(); m1_rsp_ready = 1'b1;
        sample();
        check("t4_release", s_rsp_ready, 1'b1);
        tick(); m1_rsp_ready = 1'b0; s_rsp_valid = 1'b0;
        sample();
        check("t4_idle", busy, 1'b0);

        // timeout: no SRAM response ever
        do_reset();
        tick(); rst_ni = 1'b1; m0_req_valid = 1'b1; s_req_ready = 1'b1;
        sample();
        tick();
        sample();
        tick(); m0_req_valid = 1'b0; m0_rsp_ready = 1'b1;
        sample();
        check("t5_err_rsp1", err, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("t5_err_early", err, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("t5_err_sticky", {err, busy}, 2'b11);
        end
        tick(); rst_ni = 1'b0;
        sample();
        check("t5_err_cleared", err, 1'b0);

        // reset while awaiting IFU response
        tick(); rst_ni = 1'b1; quiet(); m0_req_valid = 1'b1; s_req_ready = 1'b1;
        sample();
        tick();
        sample();
        tick(); m0_req_valid = 1'b0; m0_rsp_ready = 1'b1;
        sample();
        check("t6_in_rsp", busy, 1'b1);
        tick(); rst_ni = 1'b0; s_rsp_valid = 1'b1; s_rdata = 32'h0000_1234;
        sample();
        check("t6_abandon", {m0_rsp_valid, busy, m0_rdata}, 34'd0);
        tick(); rst_ni = 1'b1;
        sample();
        check("t6_late_rsp", {m0_rsp_valid, s_rsp_ready}, 2'b00);

        // randomized traffic; granted requester holds its request until accepted
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_ni = ($urandom_range(0, 199) != 0);
            if (!(md_phase == 1 && md_owner == 0)) begin
                m0_req_valid = ($urandom_range(0, 2) != 0);
                m0_addr = $urandom;
            end
            if (!(md_phase == 1 && md_owner == 1)) begin
                m1_req_valid = ($urandom_range(0, 2) != 0);
                m1_addr = $urandom;
                m1_wen = $urandom_range(0, 1);
                m1_wdata = $urandom;
                m1_wmask = 4'($urandom_range(0, 15));
            end
            s_req_ready = ($urandom_range(0, 3) != 0);
            s_rsp_valid = ($urandom_range(0, 2) != 0);
            s_rdata = $urandom;
            m0_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        sample();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
